inv_mix_columns_seq: RTL and testbench

INV_MIX_COLUMNS_SEQ -- requirements
Module: inv_mix_columns_seq

---
 rtl/inv_mix_columns_seq_pkg.sv | 38 +++
 rtl/inv_mix_single_column.sv | 24 ++
 rtl/inv_mix_columns_seq.sv | 77 +++++++
 tb/tb_inv_mix_columns_seq.sv | 235 +++++++++++++++++++++++
 4 files changed

// File: rtl/inv_mix_columns_seq_pkg.sv
// Shared definitions for the sequential AES InvMixColumns block: FSM encoding,
// GF(2^8) constants and the xtime-based multiply helpers.
package inv_mix_columns_seq_pkg;

  localparam int STATE_W = 128;
  localparam int COL_W   = 32;

  localparam logic [8:0] GF_POLY = 9'h11B;

  localparam logic [7:0] COEF_09 = 8'h09;
  localparam logic [7:0] COEF_0B = 8'h0b;
  localparam logic [7:0] COEF_0D = 8'h0d;
  localparam logic [7:0] COEF_0E = 8'h0e;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } fsmState_t;

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? GF_POLY[7:0] : 8'h00);
  endfunction

  // All InvMixColumns coefficients fit in 4 bits, so three xtime steps suffice.
  function automatic logic [7:0] gfMulSmall(input logic [7:0] b, input logic [3:0] coef);
    logic [7:0] acc;
    logic [7:0] pow;
    acc = '0;
    pow = b;
    for (int i = 0; i < 4; i++) begin
      if (coef[i]) acc = acc ^ pow;
      pow = xtime(pow);
    end
    return acc;
  endfunction

endpackage

// File: rtl/inv_mix_single_column.sv
// Combinational InvMixColumns of one 32-bit column; byte 0 is the most
// significant byte of colIn, matching the state byte ordering.
module inv_mix_single_column
  import inv_mix_columns_seq_pkg::*;
(
  input  logic [0:COL_W-1] colIn,
  output logic [0:COL_W-1] colOut
);

  logic [7:0] colByte [4];

  for (genvar i = 0; i < 4; i++) begin : g_split
    assign colByte[i] = colIn[8*i +: 8];
  end

  // Each output row is the coefficient row {0e 0b 0d 09} rotated right by the row index.
  for (genvar r = 0; r < 4; r++) begin : g_row
    assign colOut[8*r +: 8] = gfMulSmall(colByte[r],         COEF_0E[3:0])
                            ^ gfMulSmall(colByte[(r+1) % 4], COEF_0B[3:0])
                            ^ gfMulSmall(colByte[(r+2) % 4], COEF_0D[3:0])
                            ^ gfMulSmall(colByte[(r+3) % 4], COEF_09[3:0]);
  end

endmodule

// File: rtl/inv_mix_columns_seq.sv
// Sequential AES InvMixColumns: one column per cycle through a shared column
// transform, valid/ready on both sides, bypass for the final decryption round.
module inv_mix_columns_seq
  import inv_mix_columns_seq_pkg::*;
(
  input  logic               clk,
  input  logic               rst_n,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [0:STATE_W-1] PrevState,
  input  logic               bypass,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [0:STATE_W-1] NextState
);

  fsmState_t          stateQ;
  fsmState_t          stateD;
  logic [1:0]         colCnt;
  logic               colsDone;
  logic [0:STATE_W-1] workState;
  logic [0:COL_W-1]   colIn;
  logic [0:COL_W-1]   colOut;
  logic               accept;

  assign in_ready  = (stateQ == IDLE) || ((stateQ == DONE) && out_ready);
  assign accept    = in_valid && in_ready;
  assign out_valid = (stateQ == DONE);
  assign colIn     = workState[COL_W*colCnt +: COL_W];

  inv_mix_single_column u_column (
    .colIn  (colIn),
    .colOut (colOut)
  );

  always_comb begin
    // NOTE: stateD defaults to stateQ first so no branch leaves it unassigned (no latch).
    stateD = stateQ;
    unique case (stateQ)
      IDLE: if (accept) stateD = bypass ? DONE : BUSY;
      BUSY: if (colsDone) stateD = DONE;
      DONE: if (out_ready) stateD = accept ? (bypass ? DONE : BUSY) : IDLE;
      default: stateD = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: non-blocking assignments so every register samples pre-edge values.
    if (!rst_n) stateQ <= IDLE;
    else        stateQ <= stateD;
  end

  // colsDone marks the extra BUSY cycle between the last column write and DONE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      // NOTE: data registers are reset as well because their zero value is visible after reset.
      workState <= '0;
      NextState <= '0;
      colCnt    <= '0;
      colsDone  <= 1'b0;
    end else if (accept) begin
      workState <= PrevState;
      colCnt    <= '0;
      colsDone  <= 1'b0;
      if (bypass) NextState <= PrevState;
    end else if (stateQ == BUSY) begin
      if (!colsDone) begin
        NextState[COL_W*colCnt +: COL_W] <= colOut;
        colCnt   <= colCnt + 2'd1;
        colsDone <= (colCnt == 2'd3);
      end else begin
        colsDone <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_inv_mix_columns_seq.sv
// Self-checking bench for inv_mix_columns_seq: a GF(2^8) reference model with a
// per-cycle scoreboard, plus directed known-answer, bypass, backpressure and reset cases.
module tb_inv_mix_columns_seq;

  logic         clk = 1'b0;
  logic         rst_n = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [0:127] PrevState = '0;
  logic         bypass = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [0:127] NextState;

  int checks = 0;
  int errors = 0;
  int cycleCnt = 0;
  bit randReady = 1'b0;

  typedef struct {
    logic [0:127] data;
    int           due;
  } exp_t;
  exp_t expQ[$];

  logic expValid;
  logic expReady;

  localparam logic [0:127] K1_IN  = 128'h8e4da1bc_00000000_00000000_00000000;
  localparam logic [0:127] K1_OUT = 128'hdb135345_00000000_00000000_00000000;
  localparam logic [0:127] K2_IN  = 128'h9fdc589d_d5d5d7d6_01010101_c6c6c6c6;
  localparam logic [0:127] K2_OUT = 128'hf20a225c_d4d4d4d5_01010101_c6c6c6c6;
  localparam logic [0:127] BYP_IN = 128'h00112233_44556677_8899aabb_ccddeeff;

  always #5 clk = ~clk;
  always @(posedge clk) cycleCnt++;

  inv_mix_columns_seq dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .PrevState (PrevState),
    .bypass    (bypass),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .NextState (NextState)
  );

  // Carry-less product followed by long division by 0x11B.
  function automatic logic [7:0] gfMul(input logic [7:0] a, input logic [7:0] b);
    logic [14:0] p;
    p = '0;
    for (int i = 0; i < 8; i++)
      if (b[i]) p = p ^ (15'(a) << i);
    for (int i = 14; i >= 8; i--)
      if (p[i]) p = p ^ (15'(9'h11B) << (i - 8));
    return p[7:0];
  endfunction

  function automatic logic [0:127] invMixModel(input logic [0:127] s);
    logic [7:0]   base [4];
    logic [0:127] res;
    logic [7:0]   acc;
    base = '{8'h0e, 8'h0b, 8'h0d, 8'h09};
    res  = '0;
    for (int c = 0; c < 4; c++) begin
      for (int r = 0; r < 4; r++) begin
        acc = '0;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gfMul(base[(k - r + 4) % 4], s[8*(4*c + k) +: 8]);
        res[8*(4*c + r) +: 8] = acc;
      end
    end
    return res;
  endfunction

  task automatic check(input string name, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic timeoutFail(input string name);
    checks++;
    errors++;
    $display("FAIL %s: timeout waiting on DUT (t=%0t)", name, $time);
  endtask

  // Scoreboard: expected handshake behaviour derived from pending results only.
  always @(negedge clk) begin
    if (rst_n) begin
      expValid = (expQ.size() > 0) && (cycleCnt >= expQ[0].due);
      expReady = (expQ.size() == 0) || (expValid && out_ready);
      check("mon_out_valid", 128'(out_valid), 128'(expValid));
      check("mon_in_ready", 128'(in_ready), 128'(expReady));
      if (expValid) check("mon_next_state", NextState, expQ[0].data);
      if (expValid && out_ready) void'(expQ.pop_front());
      if (in_valid && expReady)
        expQ.push_back('{data: bypass ? PrevState : invMixModel(PrevState),
                         due:  cycleCnt + (bypass ? 1 : 6)});
    end
  end

  // Called and returns at posedge+1.
  task automatic sendState(input logic [0:127] d, input logic b);
    PrevState = d;
    bypass    = b;
    in_valid  = 1'b1;
    for (int i = 0; i < 64; i++) begin
      @(negedge clk);
      if (in_ready) begin
        @(posedge clk); #1;
        in_valid = 1'b0;
        if (randReady) out_ready = 1'($urandom_range(0, 1));
        return;
      end
      @(posedge clk); #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
    in_valid = 1'b0;
    timeoutFail("send_accept");
  endtask

  task automatic idleCycles(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      if (randReady) out_ready = 1'($urandom_range(0, 1));
    end
  endtask

  task automatic waitOut(input string name, input logic [0:127] exp);
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid) begin
        check(name, NextState, exp);
        @(posedge clk); #1;
        return;
      end
    end
    timeoutFail(name);
  endtask

  initial begin
    logic [0:127] d;
    bit           drained;

    check("model_gfmul", 128'(gfMul(8'h57, 8'h13)), 128'(8'hfe));
    check("model_known_col", invMixModel(K1_IN), K1_OUT);
    check("model_full_state", invMixModel(K2_IN), K2_OUT);

    #1 rst_n = 1'b0;
    #2;
    check("reset_out_valid", 128'(out_valid), 128'(1'b0));
    check("reset_next_state", NextState, '0);
    check("reset_in_ready", 128'(in_ready), 128'(1'b1));
    repeat (3) @(posedge clk);
    #2 rst_n = 1'b1;
    @(posedge clk); #1;

    out_ready = 1'b1;
    sendState(K1_IN, 1'b0);
    waitOut("known_col", K1_OUT);
    sendState(K2_IN, 1'b0);
    waitOut("full_state", K2_OUT);

    sendState(BYP_IN, 1'b1);
    @(negedge clk);
    check("bypass_valid", 128'(out_valid), 128'(1'b1));
    check("bypass_data", NextState, BYP_IN);
    @(posedge clk); #1;

    // Backpressure, then a same-edge consume/accept handoff.
    out_ready = 1'b0;
    sendState(K1_IN, 1'b0);
    waitOut("bp_first", K1_OUT);
    PrevState = K2_IN;
    bypass    = 1'b0;
    in_valid  = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("bp_stable", NextState, K1_OUT);
      check("bp_in_ready", 128'(in_ready), 128'(1'b0));
      check("bp_out_valid", 128'(out_valid), 128'(1'b1));
    end
    @(posedge clk); #1;
    out_ready = 1'b1;
    @(negedge clk);
    check("handoff_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    in_valid = 1'b0;
    for (int i = 1; i <= 6; i++) begin
      @(negedge clk);
      check("b2b_latency", 128'(out_valid), 128'(i == 6));
    end
    check("b2b_data", NextState, K2_OUT);
    @(posedge clk); #1;

    // Reset while the column counter is at 2.
    sendState(K2_IN, 1'b0);
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b0;
    expQ.delete();
    #1;
    check("rst_out_valid", 128'(out_valid), 128'(1'b0));
    check("rst_next_state", NextState, '0);
    #3 rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", 128'(in_ready), 128'(1'b1));
    @(posedge clk); #1;
    sendState(K1_IN, 1'b0);
    waitOut("post_rst", K1_OUT);

    randReady = 1'b1;
    repeat (40) begin
      d = {$urandom(), $urandom(), $urandom(), $urandom()};
      sendState(d, 1'($urandom_range(0, 3) == 0));
      idleCycles(int'($urandom_range(0, 2)));
    end
    randReady = 1'b0;
    out_ready = 1'b1;
    drained   = 1'b0;
    for (int i = 0; i < 50 && !drained; i++) begin
      @(posedge clk); #1;
      drained = (expQ.size() == 0);
    end
    if (!drained) timeoutFail("drain");

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
